instr_rom_loader: RTL
=====================

# instr_rom_loader

Instruction-memory responder for `mips_cpu_harvard`: the target end of the CPU's instruction-fetch port, replacing per-test hand-written address decoders. After reset it accepts a program as a byte stream through a valid/ready load port and packs it into words. It then serves `instr_readdata` for any `instr_address` the CPU presents, mapping the reset vector region to the stored words and flagging illegal fetches. It sits beside `data_memory` in every CPU testbench and in the top-level harness.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit instruction words stored.
- `BASE_ADDR`, default 32'hBFC00000: byte address of stored word 0 (the reset vector).
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: asynchronous, active-high.
- `clk_enable` input, 1: all state updates qualified by it; combinational read unaffected.
- `load_valid` input, 1: `load_byte` is valid.
- `load_ready` output, 1: loader can accept a byte.
- `load_byte` input, 8: program byte.
- `load_last` input, 1: marks the final byte of the program.
- `load_done` output, 1: program loaded, fetch serving active.
- `loaded_words` output, $clog2(DEPTH_WORDS)+1: words written so far.
- `instr_address` input, 32: CPU fetch address.
- `instr_readdata` output, 32: fetched instruction (combinational).
- `fault` output, 1: sticky error flag.

## Operation
- FSM states are LOAD and RUN. Reset forces LOAD.
- LOAD:
  - `load_ready`=1.
  - A byte is accepted on a rising edge with `load_valid & load_ready & clk_enable`.
  - Bytes are packed little-endian: the 1st byte goes to [7:0] and the 4th to [31:24].
  - The byte lane counter (0-3) and word pointer advance per accepted byte. The word is written to `mem[ptr]` when the 4th byte is accepted, and `loaded_words` increments.
- `load_last` on an accepted byte:
  - Any partial word is written with its unfilled upper lanes zero, and counts as a loaded word.
  - The FSM then goes to RUN.
- Overflow: a byte accepted when `loaded_words`==DEPTH_WORDS is dropped and sets `fault`. `load_last` on such a byte still moves the FSM to RUN.
- RUN: `load_ready`=0, `load_done`=1. Load-port inputs are ignored. The state is left only by reset.
- Read path (combinational, every state). Word index = (`instr_address`-BASE_ADDR)>>2.
  - In LOAD, `instr_readdata`=0.
  - In RUN with an aligned address and index < `loaded_words`, `instr_readdata`=`mem[index]`.
  - In RUN with an aligned address, index < DEPTH_WORDS but ≥ `loaded_words`, `instr_readdata`=0 (nop).
  - `instr_address`==0 (the CPU halt address) returns 0 and is legal.
  - Any other address (unaligned, below BASE_ADDR, or beyond DEPTH_WORDS) returns 0. On the next enabled edge in RUN it sets `fault`.
- Address arithmetic is 32-bit unsigned with wrap. Addresses below BASE_ADDR wrap to a huge index and so are out of range.
- `fault` is cleared only by reset.
- Memory contents are not cleared by reset. Stale words are unreachable because of the `loaded_words` gating.

## Timing
- Reset values: `load_ready`=1, `load_done`=0, `loaded_words`=0, `fault`=0, `instr_readdata`=0 (the state is LOAD).
- Byte-accept to `loaded_words` update: 1 cycle, visible after the edge that accepts the 4th or last byte.
- `load_done` rises on the edge that accepts `load_last`. `load_ready` falls on the same edge.
- Fetch latency: 0 cycles. `instr_readdata` follows `instr_address` in the same cycle, as the CPU requires.
- Fault from an illegal fetch is registered 1 cycle after the address is presented with `clk_enable`=1.
- With `clk_enable`=0: no byte is accepted, even with `load_valid`=1, and no state changes. Reads still respond.
- Reset asserted mid-load: immediate return to LOAD, with lane, pointer, `loaded_words` and `fault` cleared. A partial word is discarded.
- Reset asserted in RUN: `instr_readdata` drops to 0 asynchronously, because the state is LOAD.

## Structure
- A shared package `mips_tb_pkg` holds:
  - `RESET_VECTOR` (32'hBFC00000) and `HALT_ADDR` (0).
  - The `loader_state_t` enum (LOAD, RUN).
  - The function `word_index(addr, base)`.
- One sub-module, `byte_packer`: the lane counter plus the 32-bit shift/assembly register. Its outputs are `word_valid`, `word`, and the partial flush on last.
- The top level holds the FSM, the memory array, the read mux and the fault logic.

## Test plan
- Load bytes 4D,00,84,24 then F5,FF,82,28 (last) -> `loaded_words`=2, `load_done`=1; fetch BFC00000 -> 2484004D, fetch BFC00004 -> 2882FFF5.
- Load 3 bytes 08,00,00 with `load_last` -> `loaded_words`=1, fetch BFC00000 -> 00000008. Fetch BFC00004 -> 0 with `fault`=0, and fetch 0 -> 0 with `fault`=0.
- DEPTH_WORDS=2: load 9 bytes, the 9th with last -> `loaded_words`=2, `fault`=1, RUN entered.
- In RUN, fetch BFC00002 (unaligned) and then 0x00000400 -> `instr_readdata`=0 for both, with `fault` set one edge after the first.
- Assert reset after 6 bytes, then reload 4 bytes 01,00,00,00 (last) -> `loaded_words`=1, fetch BFC00000 -> 00000001, `fault`=0.
- Hold `clk_enable`=0 with `load_valid`=1 for 5 cycles -> `loaded_words` and the lane counter are unchanged, and `load_ready` stays 1.

Source files
------------

// File: rtl/mips_tb_pkg.sv
// rtl/mips_tb_pkg.sv - shared constants, loader state type and address helper for the CPU harness
package mips_tb_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
   localparam logic [31:0] HALT_ADDR    = 32'h00000000;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } loader_state_t;

   // Unsigned wrap makes addresses below base land on a huge index.
   function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word packer with partial flush on last
module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        accept,
   input  logic [7:0]  data_byte,
   input  logic        last,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  lane;
   logic [23:0] held;

   // The word always includes the byte being accepted; unfilled lanes read as zero.
   always_comb begin
      word = 32'h0;
      case (lane)
         2'd0: word = {24'h0, data_byte};
         2'd1: word = {16'h0, data_byte, held[7:0]};
         2'd2: word = {8'h0, data_byte, held[15:0]};
         2'd3: word = {data_byte, held[23:0]};
         default: word = 32'h0;
      endcase
   end

   assign word_valid = accept & ((lane == 2'd3) | last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane <= 2'd0;
         held <= 24'h0;
      end else if (accept) begin
         if (word_valid) begin
            lane <= 2'd0;
            held <= 24'h0;
         end else begin
            lane <= lane + 2'd1;
            held <= word[23:0];
         end
      end
   end

endmodule

// File: rtl/instr_rom_loader.sv
// rtl/instr_rom_loader.sv - byte-stream program loader and zero-latency instruction fetch responder
module instr_rom_loader
   import mips_tb_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = RESET_VECTOR
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clk_enable,
   input  logic                           load_valid,
   output logic                           load_ready,
   input  logic [7:0]                     load_byte,
   input  logic                           load_last,
   output logic                           load_done,
   output logic [$clog2(DEPTH_WORDS):0]   loaded_words,
   input  logic [31:0]                    instr_address,
   output logic [31:0]                    instr_readdata,
   output logic                           fault
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int LW = AW + 1;

   loader_state_t state, next_state;

   logic        handshake;
   logic        full;
   logic        accept;
   logic        word_valid;
   logic [31:0] word;
   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] idx;
   logic        aligned;
   logic        fetch_legal;
   logic        hit;

   assign handshake = load_valid & load_ready & clk_enable;
   assign full      = (loaded_words == LW'(DEPTH_WORDS));
   assign accept    = handshake & ~full;

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .accept     (accept),
      .data_byte  (load_byte),
      .last       (load_last),
      .word_valid (word_valid),
      .word       (word)
   );

   // Contents survive reset; loaded_words gating hides stale words.
   always_ff @(posedge clk) begin
      if (word_valid)
         mem[loaded_words[AW-1:0]] <= word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= LOAD;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      load_ready = 1'b0;
      load_done  = 1'b0;
      case (state)
         LOAD: begin
            load_ready = 1'b1;
            if (handshake && load_last)
               next_state = RUN;
         end
         RUN: begin
            load_done = 1'b1;
         end
         default: next_state = LOAD;
      endcase
   end

   assign idx         = word_index(instr_address, BASE_ADDR);
   assign aligned     = (instr_address[1:0] == 2'b00);
   assign fetch_legal = (instr_address == HALT_ADDR) | (aligned & (idx < 32'(DEPTH_WORDS)));
   assign hit         = (state == RUN) & aligned & (idx < 32'(loaded_words));

   assign instr_readdata = hit ? mem[idx[AW-1:0]] : 32'h0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         loaded_words <= '0;
         fault        <= 1'b0;
      end else begin
         if (word_valid)
            loaded_words <= loaded_words + LW'(1);
         if (handshake && full)
            fault <= 1'b1;
         if (clk_enable && (state == RUN) && !fetch_legal)
            fault <= 1'b1;
      end
   end

endmodule
